// File: rtl/aclk_pkg.sv
// Shared state encoding and constants for the alarm-clock mode controller.
package aclk_pkg;

    typedef enum logic [2:0] {
        SHOW_TIME        = 3'd0,
        KEY_STORED       = 3'd1,
        KEY_WAITED       = 3'd2,
        KEY_ENTRY        = 3'd3,
        SHOW_ALARM       = 3'd4,
        SET_ALARM_TIME   = 3'd5,
        SET_CURRENT_TIME = 3'd6
    } state_t;

    localparam logic [3:0] NOKEY           = 4'd10;
    localparam int         TIMEOUT_DEFAULT = 10;

endpackage

// File: rtl/aclk_mode_ctrl_if.sv
// Keypad/button inputs and display/strobe outputs of the mode controller.
interface aclk_mode_ctrl_if;
    import aclk_pkg::*;

    logic       one_second;
    logic [3:0] key;
    logic       alarm_button;
    logic       time_button;
    logic       shift;
    logic       load_new_a;
    logic       load_new_c;
    logic       show_a;
    logic       show_new_time;

    modport master (
        output one_second, key, alarm_button, time_button,
        input  shift, load_new_a, load_new_c, show_a, show_new_time
    );

    modport slave (
        input  one_second, key, alarm_button, time_button,
        output shift, load_new_a, load_new_c, show_a, show_new_time
    );

endinterface

// File: rtl/aclk_timeout_cnt.sv
// Seconds-of-inactivity counter; used only when ACLK_KEY_TIMEOUT_EN is defined.
// expired is combinational and the count restarts from 0 on that same edge.
module aclk_timeout_cnt
    import aclk_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    input  logic tick,
    output logic expired
);

    localparam logic [3:0] LAST = 4'(TIMEOUT - 1);

    logic [3:0] r_count;

    assign expired = enable && tick && (r_count == LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && tick) begin
            r_count <= expired ? 4'd0 : r_count + 4'd1;
        end
    end

endmodule

// File: rtl/aclk_mode_ctrl.sv
// Alarm-clock mode sequencer: keypad/buttons/1 Hz tick to display selects and load strobes.
// Moore outputs; entry timeout present only when ACLK_KEY_TIMEOUT_EN is defined.
module aclk_mode_ctrl
    import aclk_pkg::*;
#(
    parameter int         TIMEOUT = aclk_pkg::TIMEOUT_DEFAULT,
    parameter logic [3:0] NOKEY   = aclk_pkg::NOKEY
) (
    input  logic              clock,
    input  logic              reset,
    aclk_mode_ctrl_if.slave   bus
);

    state_t r_state;
    state_t w_next;
    logic   w_key_vld;
    logic   w_in_entry;
    logic   w_timeout;

    assign w_key_vld  = (bus.key != NOKEY);
    assign w_in_entry = (r_state == KEY_WAITED) || (r_state == KEY_ENTRY);

`ifdef ACLK_KEY_TIMEOUT_EN
    aclk_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout_cnt (
        .clock   (clock),
        .reset   (reset),
        .clear   (!w_in_entry),
        .enable  (w_in_entry),
        .tick    (bus.one_second),
        .expired (w_timeout)
    );
`else
    logic w_unused_tick;
    assign w_unused_tick = bus.one_second;
    assign w_timeout     = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= SHOW_TIME;
        end else begin
            r_state <= w_next;
        end
    end

    // Buttons beat a new key, a new key beats the timeout.
    always_comb begin
        w_next = SHOW_TIME;
        case (r_state)
            SHOW_TIME: begin
                if (bus.alarm_button)   w_next = SHOW_ALARM;
                else if (w_key_vld)     w_next = KEY_STORED;
                else                    w_next = SHOW_TIME;
            end
            KEY_STORED:                 w_next = KEY_WAITED;
            KEY_WAITED: begin
                if (!w_key_vld)         w_next = KEY_ENTRY;
                else if (w_timeout)     w_next = SHOW_TIME;
                else                    w_next = KEY_WAITED;
            end
            KEY_ENTRY: begin
                if (bus.alarm_button)   w_next = SET_ALARM_TIME;
                else if (bus.time_button) w_next = SET_CURRENT_TIME;
                else if (w_key_vld)     w_next = KEY_STORED;
                else if (w_timeout)     w_next = SHOW_TIME;
                else                    w_next = KEY_ENTRY;
            end
            SHOW_ALARM: begin
                if (!bus.alarm_button)  w_next = SHOW_TIME;
                else                    w_next = SHOW_ALARM;
            end
            SET_ALARM_TIME:             w_next = SHOW_TIME;
            SET_CURRENT_TIME:           w_next = SHOW_TIME;
            default:                    w_next = SHOW_TIME;
        endcase
    end

    logic w_shift;
    logic w_load_a;
    logic w_load_c;
    logic w_show_a;
    logic w_show_new;

    always_comb begin
        w_shift    = 1'b0;
        w_load_a   = 1'b0;
        w_load_c   = 1'b0;
        w_show_a   = 1'b0;
        w_show_new = 1'b0;
        case (r_state)
            KEY_STORED: begin
                w_shift    = 1'b1;
                w_show_new = 1'b1;
            end
            KEY_WAITED:       w_show_new = 1'b1;
            KEY_ENTRY:        w_show_new = 1'b1;
            SHOW_ALARM:       w_show_a   = 1'b1;
            SET_ALARM_TIME:   w_load_a   = 1'b1;
            SET_CURRENT_TIME: w_load_c   = 1'b1;
            default: begin
                w_shift    = 1'b0;
                w_show_new = 1'b0;
            end
        endcase
    end

    assign bus.shift         = w_shift;
    assign bus.load_new_a    = w_load_a;
    assign bus.load_new_c    = w_load_c;
    assign bus.show_a        = w_show_a;
    assign bus.show_new_time = w_show_new;

endmodule

// File: tb/tb_aclk_mode_ctrl.sv
// Scoreboard bench for aclk_mode_ctrl: directed test-plan sequences, then random traffic.
module tb_aclk_mode_ctrl;

    localparam int         TOUT = 10;
    localparam logic [3:0] NK   = 4'd10;

    localparam int M_IDLE   = 0;
    localparam int M_ALARM  = 1;
    localparam int M_ENTER  = 2;
    localparam int M_COMMIT = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;

    aclk_mode_ctrl_if bus();

    aclk_mode_ctrl #(.TIMEOUT(TOUT), .NOKEY(NK)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int n_shift = 0;
    int n_la = 0;
    int n_lc = 0;
    int n_showa = 0;

    logic [4:0] exp_q[$];

    int m_mode, m_secs;
    bit m_press, m_held, m_la, m_lc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [4:0] dut_out();
        return {bus.shift, bus.load_new_a, bus.load_new_c, bus.show_a, bus.show_new_time};
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_secs = 0;
        m_press = 0; m_held = 0; m_la = 0; m_lc = 0;
    endtask

    function automatic logic [4:0] model_out();
        return {m_press && m_mode == M_ENTER, m_la, m_lc,
                m_mode == M_ALARM, m_mode == M_ENTER};
    endfunction

    // Entry view: a key press shows one shift cycle, then the key is held until released;
    // only a released entry accepts buttons. Seconds count while waiting in entry.
    task automatic model_edge(input logic [3:0] k, input logic a, input logic t, input logic s);
        bit counting, tmo;
        counting = (m_mode == M_ENTER) && !m_press;
`ifdef ACLK_KEY_TIMEOUT_EN
        tmo = counting && s && (m_secs == TOUT - 1);
`else
        tmo = 1'b0;
`endif
        if (!counting)  m_secs = 0;
        else if (s)     m_secs = tmo ? 0 : m_secs + 1;
        case (m_mode)
            M_IDLE: begin
                if (a) m_mode = M_ALARM;
                else if (k != NK) begin m_mode = M_ENTER; m_press = 1; m_held = 1; end
            end
            M_ALARM: if (!a) m_mode = M_IDLE;
            M_ENTER: begin
                if (m_press) m_press = 0;
                else if (m_held) begin
                    if (k == NK) m_held = 0;
                    else if (tmo) m_mode = M_IDLE;
                end
                else if (a) begin m_mode = M_COMMIT; m_la = 1; end
                else if (t) begin m_mode = M_COMMIT; m_lc = 1; end
                else if (k != NK) begin m_press = 1; m_held = 1; end
                else if (tmo) m_mode = M_IDLE;
            end
            default: begin m_mode = M_IDLE; m_la = 0; m_lc = 0; end
        endcase
    endtask

    task automatic step(input logic [3:0] k, input logic a, input logic t, input logic s);
        bus.key = k; bus.alarm_button = a; bus.time_button = t; bus.one_second = s;
        @(posedge clock);
        model_edge(k, a, t, s);
        exp_q.push_back(model_out());
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(NK, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic enter_digits();
        for (int d = 1; d <= 4; d++) begin
            step(4'(d), 1'b0, 1'b0, 1'b0);
            step(NK, 1'b0, 1'b0, 1'b0);
            step(NK, 1'b0, 1'b0, 1'b0);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            n_shift += int'(bus.shift);
            n_la    += int'(bus.load_new_a);
            n_lc    += int'(bus.load_new_c);
            n_showa += int'(bus.show_a);
            if (exp_q.size() > 0) chk("cycle_outputs", 32'(dut_out()), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    int s0, a0, c0, h0;

    initial begin
        bus.key = NK; bus.alarm_button = 0; bus.time_button = 0; bus.one_second = 0;
        model_reset();
        #3;
        chk("reset_outputs", 32'(dut_out()), 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        idle(3);

        // four digits then time_button
        s0 = n_shift; a0 = n_la; c0 = n_lc;
        enter_digits();
        step(NK, 1'b0, 1'b1, 1'b0);
        idle(2);
        chk("digits_shift_count", 32'(n_shift - s0), 32'd4);
        chk("digits_load_c_count", 32'(n_lc - c0), 32'd1);
        chk("digits_load_a_count", 32'(n_la - a0), 32'd0);

        // key held for 20 cycles
        s0 = n_shift;
        for (int i = 0; i < 20; i++) step(4'd1, 1'b0, 1'b0, 1'b0);
        @(negedge clock); #1;
        chk("held_shift_count", 32'(n_shift - s0), 32'd1);
        chk("held_show_new", 32'(bus.show_new_time), 32'd1);
        step(NK, 1'b0, 1'b0, 1'b0);
        step(NK, 1'b0, 1'b1, 1'b0);
        idle(2);

        // both buttons together commit as alarm
        a0 = n_la; c0 = n_lc;
        enter_digits();
        step(NK, 1'b1, 1'b1, 1'b0);
        step(NK, 1'b0, 1'b0, 1'b0);
        idle(2);
        chk("both_load_a_count", 32'(n_la - a0), 32'd1);
        chk("both_load_c_count", 32'(n_lc - c0), 32'd0);

        // alarm button held 5 cycles in SHOW_TIME
        h0 = n_showa; a0 = n_la; c0 = n_lc;
        for (int i = 0; i < 5; i++) step(NK, 1'b1, 1'b0, 1'b0);
        idle(3);
        chk("alarm_show_a_count", 32'(n_showa - h0), 32'd5);
        chk("alarm_no_loads", 32'((n_la - a0) + (n_lc - c0)), 32'd0);

`ifdef ACLK_KEY_TIMEOUT_EN
        a0 = n_la; c0 = n_lc;
        step(4'd7, 1'b0, 1'b0, 1'b0);
        idle(2);
        for (int i = 1; i <= 10; i++) begin
            step(NK, 1'b0, 1'b0, 1'b1);
            if (i == 9)  chk("timeout_before", 32'(bus.show_new_time), 32'd1);
            if (i == 10) chk("timeout_at_tenth", 32'(bus.show_new_time), 32'd0);
            step(NK, 1'b0, 1'b0, 1'b0);
        end
        step(4'd7, 1'b0, 1'b0, 1'b0);
        idle(2);
        for (int i = 1; i <= 8; i++) step(NK, 1'b0, 1'b0, 1'b1);
        step(4'd3, 1'b0, 1'b0, 1'b1);
        idle(2);
        for (int i = 1; i <= 10; i++) begin
            step(NK, 1'b0, 1'b0, 1'b1);
            if (i == 9)  chk("restart_before", 32'(bus.show_new_time), 32'd1);
            if (i == 10) chk("restart_at_tenth", 32'(bus.show_new_time), 32'd0);
        end
        idle(2);
        chk("timeout_no_loads", 32'((n_la - a0) + (n_lc - c0)), 32'd0);
`endif

        // reset while in KEY_ENTRY
        step(4'd5, 1'b0, 1'b0, 1'b0);
        idle(2);
        chk("pre_reset_entry", 32'(bus.show_new_time), 32'd1);
        @(negedge clock); #2;
        reset = 1'b1;
        #1;
        chk("async_reset_outputs", 32'(dut_out()), 32'd0);
        model_reset();
        bus.time_button = 1'b1;
        @(posedge clock); #1;
        chk("held_reset_outputs", 32'(dut_out()), 32'd0);
        bus.time_button = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        idle(4);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            logic [3:0] k;
            k = ($urandom_range(0, 9) < 6) ? NK : 4'($urandom_range(0, 15));
            step(k, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 4) == 0);
        end

        @(negedge clock); #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
